// File: rtl/mem_port_arbiter_if.sv
// mem_port_arbiter_if: requester, halt and memory-side signals
// of the fetch/data memory port arbiter.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16
);

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_valid;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_valid;

  logic              halt;

  logic              mem_en;
  logic              mem_wr;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              halted;

  modport slave (
    input  if_req,
    input  if_addr,
    output if_rdata,
    output if_valid,
    input  d_req,
    input  d_we,
    input  d_addr,
    input  d_wdata,
    output d_rdata,
    output d_valid,
    input  halt,
    output mem_en,
    output mem_wr,
    output mem_addr,
    output mem_wdata,
    input  mem_rdata,
    output busy,
    output halted
  );

  modport master (
    output if_req,
    output if_addr,
    input  if_rdata,
    input  if_valid,
    output d_req,
    output d_we,
    output d_addr,
    output d_wdata,
    input  d_rdata,
    input  d_valid,
    output halt,
    input  mem_en,
    input  mem_wr,
    input  mem_addr,
    input  mem_wdata,
    output mem_rdata,
    input  busy,
    input  halted
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one single-ported memory shared by fetch and data.
// Define FAIR_ARB_EN for round-robin on ties (default: data over fetch).
module mem_port_arbiter #(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int MEM_LAT = 4
) (
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    HALTED
  } state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t state_q;
  state_t state_d;

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  logic halt_q;
  logic own_d_q;

  logic gnt_d;
  logic gnt_i;
  logic pick_d;
  logic d_pend;
  logic i_pend;
  logic cap;

  logic en_q;
  logic wr_q;
  logic iv_q;
  logic dv_q;
  logic busy_q;
  logic hlt_q;

  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] ird_q;
  logic [DATA_W-1:0] drd_q;

  // a requester still holding req in its valid cycle is not re-granted
  assign d_pend = bus.d_req & ~dv_q;
  assign i_pend = bus.if_req & ~iv_q;

`ifdef FAIR_ARB_EN
  logic last_d_q;

  // on a tie, whoever lost the previous grant wins this one
  assign pick_d = d_pend & (~i_pend | ~last_d_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_d_q <= 1'b0;
    end else if (gnt_d | gnt_i) begin
      last_d_q <= gnt_d;
    end
  end
`else
  assign pick_d = d_pend;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gnt_d   = 1'b0;
    gnt_i   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (halt_q | bus.halt) begin
          state_d = HALTED;
        end else if (pick_d) begin
          gnt_d   = 1'b1;
          state_d = ISSUE;
        end else if (i_pend) begin
          gnt_i   = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d   = LAT;
        state_d = WAIT;
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
        end
      end
      HALTED: begin
        state_d = HALTED;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // memory read data is valid in the cycle the counter sits at 1
  assign cap = (state_q == WAIT) && (cnt_q == 4'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      halt_q  <= 1'b0;
      own_d_q <= 1'b0;
      en_q    <= 1'b0;
      wr_q    <= 1'b0;
      iv_q    <= 1'b0;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
      hlt_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      ird_q   <= '0;
      drd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (bus.halt) begin
        halt_q <= 1'b1;
      end
      en_q <= gnt_d | gnt_i;
      wr_q <= gnt_d & bus.d_we;
      if (gnt_d) begin
        own_d_q <= 1'b1;
        addr_q  <= bus.d_addr;
        wdata_q <= bus.d_wdata;
      end else if (gnt_i) begin
        own_d_q <= 1'b0;
        addr_q  <= bus.if_addr;
        wdata_q <= '0;
      end
      iv_q <= cap & ~own_d_q;
      dv_q <= cap & own_d_q;
      if (cap & ~own_d_q) begin
        ird_q <= bus.mem_rdata;
      end
      if (cap & own_d_q) begin
        drd_q <= bus.mem_rdata;
      end
      busy_q <= (state_d == ISSUE) || (state_d == WAIT);
      hlt_q  <= (state_d == HALTED);
    end
  end

  assign bus.mem_en    = en_q;
  assign bus.mem_wr    = wr_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.if_valid  = iv_q;
  assign bus.if_rdata  = ird_q;
  assign bus.d_valid   = dv_q;
  assign bus.d_rdata   = drd_q;
  assign bus.busy      = busy_q;
  assign bus.halted    = hlt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed vectors, corner sequences and a
// randomized run against a cycle-timeline model of the arbiter.
module tb_mem_port_arbiter;

  localparam int LAT = 4;
  localparam int RN  = 1500;
  localparam int RS  = RN + 16;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  mem_port_arbiter_if b ();
  mem_port_arbiter_if b1 ();

  mem_port_arbiter #(.MEM_LAT(LAT)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b)
  );

  mem_port_arbiter #(.MEM_LAT(1)) dut1 (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (b1)
  );

  typedef struct {
    int          due;
    logic [15:0] d;
  } rsp_t;

  typedef struct {
    bit          is_d;
    bit          we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } vec_t;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  rsp_t q4[$];
  rsp_t q1[$];

  bit          e_en  [RS];
  bit          e_wr  [RS];
  bit          e_iv  [RS];
  bit          e_dv  [RS];
  bit          e_st  [RS];
  bit          e_busy[RS];
  bit          e_hlt [RS];
  logic [15:0] e_addr[RS];
  logic [15:0] e_wd  [RS];
  logic [15:0] e_rd  [RS];

  function automatic logic [15:0] memv(input logic [15:0] a);
    return a ^ 16'hA163;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // one clock; the memory model answers MEM_LAT cycles after mem_en
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (b.mem_en) q4.push_back('{cyc + LAT, memv(b.mem_addr)});
    if (b1.mem_en) q1.push_back('{cyc + 1, memv(b1.mem_addr)});
    if (q4.size() > 0 && q4[0].due == cyc) begin
      b.mem_rdata = q4[0].d;
      void'(q4.pop_front());
    end else begin
      b.mem_rdata = 16'($urandom);
    end
    if (q1.size() > 0 && q1[0].due == cyc) begin
      b1.mem_rdata = q1[0].d;
      void'(q1.pop_front());
    end else begin
      b1.mem_rdata = 16'($urandom);
    end
  endtask

  task automatic idle_inputs();
    b.if_req   = 0;
    b.if_addr  = 0;
    b.d_req    = 0;
    b.d_we     = 0;
    b.d_addr   = 0;
    b.d_wdata  = 0;
    b.halt     = 0;
    b1.if_req  = 0;
    b1.if_addr = 0;
    b1.d_req   = 0;
    b1.d_we    = 0;
    b1.d_addr  = 0;
    b1.d_wdata = 0;
    b1.halt    = 0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, ".ctl"}, {b.if_valid, b.d_valid, b.mem_en,
                       b.mem_wr, b.busy, b.halted}, 0);
    chk({nm, ".dat"}, {b.if_rdata, b.d_rdata,
                       b.mem_addr, b.mem_wdata}, 0);
    chk({nm, ".ctl1"}, {b1.if_valid, b1.d_valid, b1.mem_en,
                        b1.mem_wr, b1.busy, b1.halted}, 0);
  endtask

  task automatic do_reset(input bit check);
    rst_n = 0;
    idle_inputs();
    q4.delete();
    q1.delete();
    #1;
    if (check) chk_zero("reset");
    tick();
    tick();
    rst_n = 1;
  endtask

  task automatic run_txn(input vec_t v);
    if (v.is_d) begin
      b.d_req   = 1;
      b.d_we    = v.we;
      b.d_addr  = v.addr;
      b.d_wdata = v.wdata;
    end else begin
      b.if_req  = 1;
      b.if_addr = v.addr;
    end
    for (int k = 1; k <= 8; k++) begin
      tick();
      if (k == 7) begin
        b.d_req  = 0;
        b.if_req = 0;
      end
      chk("txn.mem_en", b.mem_en, k == 1);
      chk("txn.busy", b.busy, k >= 1 && k <= 5);
      chk("txn.if_valid", b.if_valid, !v.is_d && k == 6);
      chk("txn.d_valid", b.d_valid, v.is_d && k == 6);
      if (k == 1) begin
        chk("txn.mem_addr", b.mem_addr, v.addr);
        chk("txn.mem_wr", b.mem_wr, v.is_d && v.we);
        if (v.we) chk("txn.mem_wdata", b.mem_wdata, v.wdata);
      end
      if (k == 6 && !v.is_d) chk("txn.if_rdata", b.if_rdata, v.rdata);
      if (k == 6 && v.is_d && !v.we)
        chk("txn.d_rdata", b.d_rdata, v.rdata);
    end
  endtask

  task automatic contention();
    bit dfirst;
    int vd;
    int vi;
`ifdef FAIR_ARB_EN
    dfirst = 0;
`else
    dfirst = 1;
`endif
    vd = dfirst ? 6 : 12;
    vi = dfirst ? 12 : 6;
    run_txn('{1'b1, 1'b1, 16'h0500, 16'h1234, 16'h0000});
    b.d_req   = 1;
    b.d_we    = 0;
    b.d_addr  = 16'h0300;
    b.if_req  = 1;
    b.if_addr = 16'h0400;
    for (int k = 1; k <= 14; k++) begin
      tick();
      if (k == vd + 1) b.d_req = 0;
      if (k == vi + 1) b.if_req = 0;
      chk("arb.mem_en", b.mem_en, k == 1 || k == 7);
      if (k == 1)
        chk("arb.addr1", b.mem_addr, dfirst ? 16'h0300 : 16'h0400);
      if (k == 7)
        chk("arb.addr2", b.mem_addr, dfirst ? 16'h0400 : 16'h0300);
      chk("arb.d_valid", b.d_valid, k == vd);
      chk("arb.if_valid", b.if_valid, k == vi);
      if (k == vd) chk("arb.d_rdata", b.d_rdata, 16'hA263);
      if (k == vi) chk("arb.if_rdata", b.if_rdata, 16'hA563);
    end
  endtask

  task automatic halt_seq();
    b.if_req  = 1;
    b.if_addr = 16'h0040;
    for (int k = 1; k <= 27; k++) begin
      tick();
      b.halt = (k == 3);
      chk("halt.if_valid", b.if_valid, k == 6);
      if (k == 6) chk("halt.if_rdata", b.if_rdata, 16'hA123);
      chk("halt.halted", b.halted, k >= 7);
      chk("halt.mem_en", b.mem_en, k == 1);
      chk("halt.busy", b.busy, k >= 1 && k <= 5);
    end
    b.if_req = 0;
  endtask

  task automatic reset_seq();
    b.d_req  = 1;
    b.d_we   = 0;
    b.d_addr = 16'h0123;
    for (int k = 1; k <= 16; k++) begin
      tick();
      if (k == 3) begin
        rst_n   = 0;
        b.d_req = 0;
        #1;
        chk_zero("rstmid");
      end
      if (k == 5) begin
        rst_n    = 1;
        b.d_req  = 1;
        b.d_addr = 16'h0456;
      end
      if (k == 12) b.d_req = 0;
      chk("rstmid.d_valid", b.d_valid, k == 11);
      if (k == 11) chk("rstmid.d_rdata", b.d_rdata, 16'hA535);
      chk("rstmid.mem_en", b.mem_en, k == 1 || k == 6);
    end
  endtask

  task automatic lat1_seq();
    b1.d_req  = 1;
    b1.d_we   = 0;
    b1.d_addr = 16'h0777;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 4) b1.d_req = 0;
      chk("lat1.mem_en", b1.mem_en, k == 1);
      chk("lat1.d_valid", b1.d_valid, k == 3);
      if (k == 3) chk("lat1.d_rdata", b1.d_rdata, 16'hA614);
    end
  endtask

  // model: a grant in cycle t owns the port until t+LAT+2
  task automatic random_run();
    int          free_at;
    int          v;
    bit          hseen;
    bit          parked;
    bit          last_d;
    bit          dok;
    bit          iok;
    bit          gd;
    logic [15:0] a;
    for (int i = 0; i < RS; i++) begin
      e_en[i]   = 0;
      e_wr[i]   = 0;
      e_iv[i]   = 0;
      e_dv[i]   = 0;
      e_st[i]   = 0;
      e_busy[i] = 0;
      e_hlt[i]  = 0;
      e_addr[i] = 0;
      e_wd[i]   = 0;
      e_rd[i]   = 0;
    end
    free_at = 0;
    hseen   = 0;
    parked  = 0;
    last_d  = 0;
    for (int t = 0; t < RN; t++) begin
      if (t > 0) tick();
      chk("rnd.mem_en", b.mem_en, e_en[t]);
      if (e_en[t]) begin
        chk("rnd.mem_addr", b.mem_addr, e_addr[t]);
        chk("rnd.mem_wr", b.mem_wr, e_wr[t]);
        if (e_wr[t]) chk("rnd.mem_wdata", b.mem_wdata, e_wd[t]);
      end
      chk("rnd.if_valid", b.if_valid, e_iv[t]);
      chk("rnd.d_valid", b.d_valid, e_dv[t]);
      if (e_iv[t]) chk("rnd.if_rdata", b.if_rdata, e_rd[t]);
      if (e_dv[t] && !e_st[t]) chk("rnd.d_rdata", b.d_rdata, e_rd[t]);
      chk("rnd.busy", b.busy, e_busy[t]);
      chk("rnd.halted", b.halted, e_hlt[t]);
      if (t > 0 && e_iv[t-1]) begin
        b.if_req = 0;
      end else if (!b.if_req && $urandom_range(0, 2) == 0) begin
        b.if_req  = 1;
        b.if_addr = 16'($urandom);
      end
      if (t > 0 && e_dv[t-1]) begin
        b.d_req = 0;
      end else if (!b.d_req && $urandom_range(0, 2) == 0) begin
        b.d_req   = 1;
        b.d_we    = 1'($urandom);
        b.d_addr  = 16'($urandom);
        b.d_wdata = 16'($urandom);
      end
      b.halt = (t > RN - 80) && ($urandom_range(0, 19) == 0);
      hseen |= b.halt;
      if (!parked && t >= free_at) begin
        if (hseen) begin
          parked = 1;
          for (int u = t + 1; u < RS; u++) e_hlt[u] = 1;
        end else begin
          dok = b.d_req && !e_dv[t];
          iok = b.if_req && !e_iv[t];
`ifdef FAIR_ARB_EN
          gd = dok && (!iok || !last_d);
`else
          gd = dok;
`endif
          if (gd || iok) begin
            a = gd ? b.d_addr : b.if_addr;
            e_en[t+1]   = 1;
            e_addr[t+1] = a;
            e_wr[t+1]   = gd && b.d_we;
            e_wd[t+1]   = b.d_wdata;
            for (int u = t + 1; u <= t + LAT + 1; u++) e_busy[u] = 1;
            v = t + LAT + 2;
            if (gd) e_dv[v] = 1;
            else e_iv[v] = 1;
            e_st[v] = gd && b.d_we;
            e_rd[v] = memv(a);
            free_at = v;
            last_d  = gd;
          end
        end
      end
    end
    b.if_req = 0;
    b.d_req  = 0;
    b.halt   = 0;
  endtask

  initial begin
    vec_t tbl[4];
    tbl[0] = '{1'b0, 1'b0, 16'h0040, 16'h0000, 16'hA123};
    tbl[1] = '{1'b1, 1'b1, 16'h1000, 16'hBEEF, 16'h0000};
    tbl[2] = '{1'b1, 1'b0, 16'h2222, 16'h0000, 16'h8341};
    tbl[3] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 16'h5E9C};
    b.mem_rdata  = 0;
    b1.mem_rdata = 0;
    do_reset(1);
    for (int i = 0; i < 4; i++) run_txn(tbl[i]);
    contention();
    do_reset(0);
    halt_seq();
    do_reset(0);
    reset_seq();
    lat1_seq();
    do_reset(0);
    random_run();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
